// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch display path: status codes,
// display clamps, the 7-segment lookup and the conversion FSM encoding.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_PAUSED  = 2'b10;

    localparam int MIN_DISP_MAX = 99;
    localparam int SEC_DISP_MAX = 59;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_LUT [10] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
    };

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_LOAD  = 2'b10
    } fsm_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        if (d > 4'd9) return 7'b0000000;
        return SEG_LUT[d];
    endfunction

endpackage

// File: rtl/stopwatch_display_if.sv
// Bundle between the stopwatch core side and the display driver; the
// display block is the slave, the core (or a bench) is the master.
interface stopwatch_display_if;
    import stopwatch_pkg::*;

    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;
    logic       upd;
    logic       ovf;
    fsm_state_t dbg_state;

    modport master (
        output minutes, seconds, status,
        input  seg, dp, an, busy, upd, ovf, dbg_state
    );

    modport slave (
        input  minutes, seconds, status,
        output seg, dp, an, busy, upd, ovf, dbg_state
    );

endinterface

// File: rtl/stopwatch_display_bin2bcd_seq.sv
// Iterative 7-bit binary to 2-digit BCD (double-dabble), one shift per cycle.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [6:0] bin_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] bcd_o
);
    // Handshake: start_i is a one-cycle request honoured whenever it is high;
    // done_o is high during the final shift and bcd_o is stable from the next
    // cycle until the following start_i.
    logic [14:0] sr_q, sr_d, adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;

    always_comb begin
        adj = sr_q;
        if (adj[10:7] >= 4'd5)  adj[10:7]  = adj[10:7] + 4'd3;
        if (adj[14:11] >= 4'd5) adj[14:11] = adj[14:11] + 4'd3;

        sr_d   = sr_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            sr_d   = {8'd0, bin_i};
            cnt_d  = 3'd0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d  = {adj[13:0], 1'b0};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd6) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == 3'd6);
    assign bcd_o  = sr_q[14:7];

endmodule

// File: rtl/stopwatch_display.sv
// Captures MM:SS from the stopwatch core, converts to BCD and scans a
// 4-digit 7-segment display with a run/pause-dependent separator dot.
module stopwatch_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_CYCLES    = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input logic clk,
    input logic rst,
    stopwatch_display_if.slave bus
);
    localparam int   CW  = $clog2(SCAN_CYCLES);
    localparam int   BW  = $clog2(BLINK_FRAMES) + 1;
    localparam logic POL = (SEG_ACTIVE_LOW != 0);

    fsm_state_t        state_q, state_d;
    logic [13:0]       cap_q, cap_d;
    logic              valid_q, valid_d, ovf_q, ovf_d, busy_q, busy_d, upd_q, upd_d;
    logic [3:0][3:0]   dig_q, dig_d;
    logic [CW-1:0]     scan_cnt_q, scan_cnt_d;
    logic [1:0]        idx_q, idx_d, status_q, status_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_q, blink_d, dp_q, dp_d;
    logic [3:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;

    logic              start, min_over, min_busy, sec_busy, min_done, sec_done;
    logic [6:0]        min_clamp, sec_clamp;
    logic [7:0]        min_bcd, sec_bcd;
    logic              wrap, frame_done, dp_on;

    assign min_over  = bus.minutes > 8'(MIN_DISP_MAX);
    assign min_clamp = min_over ? 7'(MIN_DISP_MAX) : bus.minutes[6:0];
    assign sec_clamp = (bus.seconds > 6'(SEC_DISP_MAX)) ? 7'(SEC_DISP_MAX) : {1'b0, bus.seconds};
    assign start     = (state_q == S_IDLE) && (!valid_q || ({bus.minutes, bus.seconds} != cap_q));

    bin2bcd_seq u_min (
        .clk(clk), .rst(rst), .start_i(start), .bin_i(min_clamp),
        .busy_o(min_busy), .done_o(min_done), .bcd_o(min_bcd)
    );

    bin2bcd_seq u_sec (
        .clk(clk), .rst(rst), .start_i(start), .bin_i(sec_clamp),
        .busy_o(sec_busy), .done_o(sec_done), .bcd_o(sec_bcd)
    );

    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        dig_d   = dig_q;
        upd_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cap_d   = {bus.minutes, bus.seconds};
                    valid_d = 1'b1;
                    ovf_d   = min_over;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Falling back to IDLE only guards against converters that lost their start
                if (min_done && sec_done)        state_d = S_LOAD;
                else if (!(min_busy || sec_busy)) state_d = S_IDLE;
            end
            S_LOAD: begin
                dig_d   = {min_bcd, sec_bcd};
                upd_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_comb begin
        wrap        = (scan_cnt_q == CW'(SCAN_CYCLES - 1));
        frame_done  = wrap && (idx_q == 2'd3);
        scan_cnt_d  = wrap ? '0 : scan_cnt_q + 1'b1;
        idx_d       = wrap ? idx_q + 2'd1 : idx_q;
        status_d    = bus.status;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (bus.status != status_q) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if ((bus.status == ST_PAUSED) && frame_done) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
        dp_on = (idx_d == 2'd2) &&
                ((bus.status == ST_RUNNING) || ((bus.status == ST_PAUSED) && blink_d));
        an_d  = an_q;
        seg_d = seg_q;
        dp_d  = dp_q;
        if (wrap) begin
            an_d  = (4'b0001 << idx_d) ^ {4{POL}};
            seg_d = seg_of(dig_q[idx_d]) ^ {7{POL}};
            dp_d  = dp_on ^ POL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cap_q       <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
            upd_q       <= 1'b0;
            dig_q       <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            status_q    <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            an_q        <= 4'b0001 ^ {4{POL}};
            seg_q       <= SEG_LUT[0] ^ {7{POL}};
            dp_q        <= POL;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
            upd_q       <= upd_d;
            dig_q       <= dig_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            status_q    <= status_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign bus.seg       = seg_q;
    assign bus.dp        = dp_q;
    assign bus.an        = an_q;
    assign bus.busy      = busy_q;
    assign bus.upd       = upd_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with a short scan period and blink rate.
module tb_stopwatch_display;
    import stopwatch_pkg::*;

    // Hand-derived active-low segment patterns for digits 0..9
    localparam logic [6:0] AL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    stopwatch_display_if bus();

    stopwatch_display #(
        .SCAN_CYCLES(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_upd(input string tag, input int exp_lat);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (bus.upd !== 1'b1 && n < 30);
        check({tag, "_upd"}, bus.upd, 1);
        check({tag, "_lat"}, n, exp_lat);
    endtask

    task automatic sync_frame(input string tag);
        int n = 0;
        while (bus.an !== 4'b0111 && n < 40) begin step(1); n++; end
        check({tag, "_sync3"}, bus.an, 4'b0111);
        n = 0;
        while (bus.an === 4'b0111 && n < 10) begin step(1); n++; end
        check({tag, "_sync0"}, bus.an, 4'b1110);
    endtask

    // Digits given as MM.SS; dp2 is the expected active-low dot on digit 2
    task automatic expect_frame(input string tag, input int m10, input int m1,
                                input int s10, input int s1, input logic dp2);
        logic [3:0] an_exp;
        logic [6:0] seg_exp;
        int n;
        exp_q.push_back(AL[s1]);
        exp_q.push_back(AL[s10]);
        exp_q.push_back(AL[m1]);
        exp_q.push_back(AL[m10]);
        sync_frame(tag);
        for (int k = 0; k < 4; k++) begin
            an_exp  = ~(4'b0001 << k);
            seg_exp = exp_q.pop_front();
            check($sformatf("%s_an%0d", tag, k), bus.an, an_exp);
            check($sformatf("%s_seg%0d", tag, k), bus.seg, seg_exp);
            check($sformatf("%s_dp%0d", tag, k), bus.dp, (k == 2) ? dp2 : 1'b1);
            n = 0;
            do begin
                n++;
                step(1);
            end while (bus.an === an_exp && n < 20);
            check($sformatf("%s_hold%0d", tag, k), n, 4);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, bus.an, 4'b1110);
        check({tag, "_seg"}, bus.seg, 7'b1000000);
        check({tag, "_dp"}, bus.dp, 1'b1);
        check({tag, "_busy"}, bus.busy, 1'b0);
        check({tag, "_upd"}, bus.upd, 1'b0);
        check({tag, "_ovf"}, bus.ovf, 1'b0);
        check({tag, "_state"}, bus.dbg_state, S_IDLE);
    endtask

    initial begin
        int n;
        int cnt;

        // 1: reset and first conversion of 00:00
        rst = 1'b1;
        bus.minutes = 8'd0;
        bus.seconds = 6'd0;
        bus.status  = ST_IDLE;
        step(2);
        check_reset_outputs("rst1");
        rst = 1'b0;
        step(1);
        check("t1_busy_on", bus.busy, 1'b1);
        check("t1_upd_early", bus.upd, 1'b0);
        wait_upd("t1", 8);
        check("t1_busy_off", bus.busy, 1'b0);
        step(1);
        check("t1_upd_pulse", bus.upd, 1'b0);
        expect_frame("t1", 0, 0, 0, 0, 1'b1);

        // 2: 12:34 running
        bus.minutes = 8'd12;
        bus.seconds = 6'd34;
        bus.status  = ST_RUNNING;
        wait_upd("t2", 9);
        check("t2_ovf", bus.ovf, 1'b0);
        expect_frame("t2", 1, 2, 3, 4, 1'b0);

        // 3: minutes clamp then recovery
        bus.minutes = 8'd150;
        bus.seconds = 6'd7;
        wait_upd("t3a", 9);
        check("t3a_ovf", bus.ovf, 1'b1);
        expect_frame("t3a", 9, 9, 0, 7, 1'b0);
        bus.minutes = 8'd5;
        step(1);
        check("t3b_ovf_clear", bus.ovf, 1'b0);
        check("t3b_busy", bus.busy, 1'b1);
        n = 0;
        while (bus.upd !== 1'b1 && n < 30) begin step(1); n++; end
        check("t3b_upd", bus.upd, 1'b1);
        expect_frame("t3b", 0, 5, 0, 7, 1'b0);

        // 3c: minutes exactly 99 is not clamped; seconds 60 shows as 59
        bus.minutes = 8'd99;
        bus.seconds = 6'd60;
        wait_upd("t3c", 9);
        check("t3c_ovf", bus.ovf, 1'b0);
        expect_frame("t3c", 9, 9, 5, 9, 1'b0);

        // 4: seconds changes while busy collapse to two conversions
        cnt = 0;
        bus.seconds = 6'd10;
        step(1);
        check("t4_busy", bus.busy, 1'b1);
        bus.seconds = 6'd11;
        step(1);
        bus.seconds = 6'd12;
        for (int i = 0; i < 38; i++) begin
            step(1);
            if (bus.upd === 1'b1) cnt++;
        end
        check("t4_upd_count", cnt, 2);
        expect_frame("t4", 9, 9, 1, 2, 1'b0);

        // 5: paused blink on digit 2, then idle keeps dp off
        sync_frame("t5");
        bus.status = ST_PAUSED;
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (bus.an !== 4'b1011 && n < 40) begin step(1); n++; end
            check($sformatf("t5_an_f%0d", i), bus.an, 4'b1011);
            check($sformatf("t5_dp_f%0d", i), bus.dp, (i == 2 || i == 3) ? 1'b0 : 1'b1);
            n = 0;
            while (bus.an === 4'b1011 && n < 10) begin step(1); n++; end
        end
        bus.status = ST_IDLE;
        cnt = 0;
        for (int i = 0; i < 64; i++) begin
            step(1);
            if (bus.dp !== 1'b1) cnt++;
        end
        check("t5_idle_dp_low", cnt, 0);

        // 6: reset in the middle of converting 59:59
        bus.minutes = 8'd59;
        bus.seconds = 6'd59;
        step(3);
        check("t6_mid_state", bus.dbg_state, S_SHIFT);
        check("t6_mid_busy", bus.busy, 1'b1);
        rst = 1'b1;
        step(1);
        check_reset_outputs("t6_rst");
        rst = 1'b0;
        wait_upd("t6", 9);
        expect_frame("t6", 5, 9, 5, 9, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
